// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode encoding, flag bit positions and per-opcode
// flag-update masks for the pipelined WISC ALU.
package alu_pipe_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 3;

  // Flag vector layout: {N, Z, V}
  localparam int unsigned FLG_V = 0;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_N = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_RED    = 4'h2,
    OP_XOR    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB
  } op_e;

  localparam logic [FLAG_W-1:0] FMASK_NONE = 3'b000;
  localparam logic [FLAG_W-1:0] FMASK_Z    = 3'b010;
  localparam logic [FLAG_W-1:0] FMASK_NZV  = 3'b111;

  // Which flag bits an opcode is allowed to commit into the flag register.
  function automatic logic [FLAG_W-1:0] flag_mask(input logic [OP_W-1:0] op);
    logic [FLAG_W-1:0] m;
    m = FMASK_NONE;
    case (op)
      OP_ADD, OP_SUB:                          m = FMASK_NZV;
      OP_RED, OP_XOR, OP_SLL, OP_SRA, OP_ROR,
      OP_PADDSB:                               m = FMASK_Z;
      default:                                 m = FMASK_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_pipe_exec.sv
// alu_pipe_exec: purely combinational execute unit for the WISC ALU op set.
// Produces the result and candidate {N,Z,V}; commit masking is done upstream.
// Ports: i_op (opcode), i_a/i_b (operands), o_result_c, o_flags_c.
// Build option: ALU_PIPE_SAT_EN makes ADD/SUB saturate on signed overflow.
module alu_pipe_exec
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  output logic [WIDTH-1:0]  o_result_c,
  output logic [FLAG_W-1:0] o_flags_c
);

  localparam int unsigned SHW    = $clog2(WIDTH);
  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned NLANES = WIDTH / 4;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [SHW-1:0]     w_sh;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_dif;
  logic               w_add_ovf;
  logic               w_sub_ovf;
  logic [2*WIDTH-1:0] w_rot;
  logic [WIDTH-1:0]   w_red;
  logic [WIDTH-1:0]   w_padd;
  logic [WIDTH-1:0]   w_res;
  logic               w_v;

  assign w_sh  = i_b[SHW-1:0];
  assign w_sum = i_a + i_b;
  assign w_dif = i_a - i_b;
  assign w_add_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
  assign w_sub_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_dif[WIDTH-1] != i_a[WIDTH-1]);
  assign w_rot = {i_a, i_a} >> w_sh;

  // Byte reduction: exact sum fits easily, so modulo-WIDTH accumulation is exact.
  always_comb begin
    w_red = '0;
    for (int i = 0; i < NBYTES; i++) begin
      w_red = w_red + WIDTH'($signed(i_a[8*i +: 8])) + WIDTH'($signed(i_b[8*i +: 8]));
    end
  end

  // Nibble-lane saturating add; overflow when the 5-bit sum's top two bits differ.
  always_comb begin
    logic [4:0] lane;
    lane   = '0;
    w_padd = '0;
    for (int i = 0; i < NLANES; i++) begin
      lane = {i_a[4*i+3], i_a[4*i +: 4]} + {i_b[4*i+3], i_b[4*i +: 4]};
      if (lane[4] != lane[3]) begin
        w_padd[4*i +: 4] = lane[4] ? 4'h8 : 4'h7;
      end else begin
        w_padd[4*i +: 4] = lane[3:0];
      end
    end
  end

  always_comb begin
    w_res = '0;
    w_v   = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_v   = w_add_ovf;
`ifdef ALU_PIPE_SAT_EN
        w_res = w_add_ovf ? (i_a[WIDTH-1] ? SMIN : SMAX) : w_sum;
`else
        w_res = w_sum;
`endif
      end
      OP_SUB: begin
        w_v   = w_sub_ovf;
`ifdef ALU_PIPE_SAT_EN
        w_res = w_sub_ovf ? (i_a[WIDTH-1] ? SMIN : SMAX) : w_dif;
`else
        w_res = w_dif;
`endif
      end
      OP_RED:         w_res = w_red;
      OP_XOR:         w_res = i_a ^ i_b;
      OP_SLL:         w_res = i_a << w_sh;
      OP_SRA:         w_res = WIDTH'($signed(i_a) >>> w_sh);
      OP_ROR:         w_res = w_rot[WIDTH-1:0];
      OP_PADDSB:      w_res = w_padd;
      OP_LW, OP_SW:   w_res = {i_a[WIDTH-1:1], 1'b0} + i_b;
      OP_LLB:         w_res = {i_a[WIDTH-1:8], i_b[7:0]};
      OP_LHB: begin
        // Replace byte 1 only; identical to {b[7:0],a[7:0]} at WIDTH=16.
        w_res       = i_a;
        w_res[15:8] = i_b[7:0];
      end
      default:        w_res = '0;
    endcase
  end

  // Reserved opcodes carry no flag meaning, so they present all-zero flags.
  always_comb begin
    o_result_c = w_res;
    o_flags_c  = '0;
    if (i_op[3:2] != 2'b11) begin
      o_flags_c[FLG_N] = w_res[WIDTH-1];
      o_flags_c[FLG_Z] = (w_res == '0);
      o_flags_c[FLG_V] = w_v;
    end
  end

  // Keep SMAX/SMIN referenced in the wrapping build.
  logic w_unused;
  assign w_unused = ^{SMAX, SMIN};

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes, synchronous
// flush and a persistent {N,Z,V} flag register committed on output handshake.
// Ports: clk, rst_n (async active-low), flush; in_valid/in_ready/in_op/in_a/
// in_b (input side); out_valid/out_ready/out_result/out_flags (output side);
// flags_q (committed flags).
// Build option: ALU_PIPE_SAT_EN (saturating ADD/SUB, handled in alu_pipe_exec).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [FLAG_W-1:0] out_flags,
  output logic [FLAG_W-1:0] flags_q
);

  logic              r_s1_valid;
  logic [OP_W-1:0]   r_s1_op;
  logic [WIDTH-1:0]  r_s1_a;
  logic [WIDTH-1:0]  r_s1_b;

  logic              r_s2_valid;
  logic [OP_W-1:0]   r_s2_op;
  logic [WIDTH-1:0]  r_s2_result;
  logic [FLAG_W-1:0] r_s2_flags;

  logic [FLAG_W-1:0] r_flags;

  logic              w_s2_load;
  logic              w_in_hs;
  logic              w_out_hs;
  logic [FLAG_W-1:0] w_mask;
  logic [WIDTH-1:0]  w_exec_result;
  logic [FLAG_W-1:0] w_exec_flags;

  alu_pipe_exec #(
    .WIDTH (WIDTH)
  ) u_exec (
    .i_op       (r_s1_op),
    .i_a        (r_s1_a),
    .i_b        (r_s1_b),
    .o_result_c (w_exec_result),
    .o_flags_c  (w_exec_flags)
  );

  // S2 (and therefore S1) may advance when S2 is empty or being drained.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !flush && (!r_s1_valid || w_s2_load);
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = r_s2_valid && out_ready && !flush;
  assign w_mask    = flag_mask(r_s2_op);

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_hs) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= in_op;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: result capture; data held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_op     <= '0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_op     <= r_s1_op;
        r_s2_result <= w_exec_result;
        r_s2_flags  <= w_exec_flags;
      end
    end
  end

  // Flag register: merge only the bits the retiring opcode owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_out_hs) begin
      r_flags <= (r_flags & ~w_mask) | (r_s2_flags & w_mask);
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_flags  = r_s2_flags;
  assign flags_q    = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;
  logic [2:0]  flags_q;

  logic        in_valid32;
  logic        in_ready32;
  logic [3:0]  in_op32;
  logic [31:0] in_a32;
  logic [31:0] in_b32;
  logic        out_valid32;
  logic        out_ready32;
  logic [31:0] out_result32;
  logic [2:0]  out_flags32;
  logic [2:0]  flags_q32;

  int n_vec = 0;
  int n_err = 0;

  alu_pipe #(.WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .flags_q(flags_q)
  );

  alu_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_op(in_op32), .in_a(in_a32), .in_b(in_b32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_result(out_result32),
    .out_flags(out_flags32), .flags_q(flags_q32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One op through an empty pipe with out_ready high; returns the presented
  // result/flags and leaves the caller at the negedge after the handshake.
  task automatic run_one(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic [2:0] fl);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency", 32'(out_valid), 32'd1);
    n = 0;
    while (!out_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    res = out_result;
    fl  = out_flags;
    @(negedge clk);
  endtask

  task automatic drive_cycle(input bit iv, input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input bit ordy, input bit fl,
                             output bit acc, output bit got, output logic [15:0] res);
    @(negedge clk);
    in_valid = iv; in_op = op; in_a = a; in_b = b; out_ready = ordy; flush = fl;
    #1;
    acc = iv && in_ready;
    got = out_valid && ordy;
    res = out_result;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [2:0]  fl;
    bit          chk_fl;
    logic [2:0]  fq;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  initial begin
    logic [15:0] res;
    logic [2:0]  fl;
    logic [15:0] first;
    logic [15:0] got_res[3];
    bit          acc, got, seen, unstable;
    int          idx, n_got, n;

    // {op, a, b, result, out_flags {N,Z,V}, check flags, flags_q after}
`ifdef ALU_PIPE_SAT_EN
    vecs[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b001, 1'b1, 3'b001};
`else
    vecs[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 3'b101, 1'b1, 3'b101};
`endif
    vecs[1]  = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 3'b010, 1'b1, 3'b010};
    vecs[2]  = '{4'h7, 16'h7777, 16'h1111, 16'h7777, 3'b000, 1'b1, 3'b000};
    vecs[3]  = '{4'h2, 16'h0102, 16'h03FC, 16'h0002, 3'b000, 1'b1, 3'b000};
    vecs[4]  = '{4'h3, 16'h1234, 16'h1234, 16'h0000, 3'b010, 1'b1, 3'b010};
    vecs[5]  = '{4'hA, 16'hABCD, 16'h0012, 16'hAB12, 3'b100, 1'b1, 3'b010};
    vecs[6]  = '{4'h4, 16'h0001, 16'h0004, 16'h0010, 3'b000, 1'b1, 3'b000};
    vecs[7]  = '{4'h5, 16'h8000, 16'h0003, 16'hF000, 3'b100, 1'b1, 3'b000};
    vecs[8]  = '{4'h6, 16'h0001, 16'h0001, 16'h8000, 3'b100, 1'b1, 3'b000};
    vecs[9]  = '{4'hB, 16'h1234, 16'h00AB, 16'hAB34, 3'b100, 1'b1, 3'b000};
    vecs[10] = '{4'h8, 16'h1001, 16'h0004, 16'h1004, 3'b000, 1'b1, 3'b000};
`ifdef ALU_PIPE_SAT_EN
    vecs[11] = '{4'h1, 16'h8000, 16'h0001, 16'h8000, 3'b101, 1'b1, 3'b101};
    vecs[12] = '{4'hC, 16'h0005, 16'h0005, 16'h0000, 3'b000, 1'b0, 3'b101};
`else
    vecs[11] = '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 3'b001, 1'b1, 3'b001};
    vecs[12] = '{4'hC, 16'h0005, 16'h0005, 16'h0000, 3'b000, 1'b0, 3'b001};
`endif
    vecs[13] = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 3'b010, 1'b1, 3'b010};
    vecs[14] = '{4'h5, 16'h4000, 16'h000F, 16'h0000, 3'b010, 1'b1, 3'b010};
    vecs[15] = '{4'h7, 16'h8888, 16'hFFFF, 16'h8888, 3'b100, 1'b1, 3'b000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    in_valid32 = 1'b0; in_op32 = '0; in_a32 = '0; in_b32 = '0; out_ready32 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_flags",  32'(out_flags),  32'd0);
    check("rst_flags_q",    32'(flags_q),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      run_one(vecs[i].op, vecs[i].a, vecs[i].b, res, fl);
      check($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].res));
      if (vecs[i].chk_fl) check($sformatf("v%0d_flags", i), 32'(fl), 32'(vecs[i].fl));
      check($sformatf("v%0d_flags_q", i), 32'(flags_q), 32'(vecs[i].fq));
    end

    // Backpressure: three ADDs offered while stalled; only two fit.
    idx = 0; seen = 0; unstable = 0; first = '0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(idx < 3, 4'h0, 16'(idx + 1), 16'(idx + 1), 1'b0, 1'b0, acc, got, res);
      if (acc) idx++;
      if (out_valid) begin
        if (!seen) first = res;
        else if (res !== first) unstable = 1;
        seen = 1;
      end
    end
    check("bp_accepted", 32'(idx), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_stable", 32'(unstable), 32'd0);
    check("bp_held_result", 32'(first), 32'd2);
    n_got = 0; n = 0;
    while (n_got < 3 && n < 10) begin
      drive_cycle(idx < 3, 4'h0, 16'(idx + 1), 16'(idx + 1), 1'b1, 1'b0, acc, got, res);
      if (acc) idx++;
      if (got) begin
        got_res[n_got] = res;
        n_got++;
      end
      n++;
    end
    drive_cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0, acc, got, res);
    check("bp_count", 32'(n_got), 32'd3);
    check("bp_res0", 32'(got_res[0]), 32'd2);
    check("bp_res1", 32'(got_res[1]), 32'd4);
    check("bp_res2", 32'(got_res[2]), 32'd6);
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Flush with two Z-setting ops in flight; flags_q stays 000.
    drive_cycle(1'b1, 4'h1, 16'h0005, 16'h0005, 1'b0, 1'b0, acc, got, res);
    drive_cycle(1'b1, 4'h3, 16'h0001, 16'h0001, 1'b0, 1'b0, acc, got, res);
    drive_cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b1, acc, got, res);
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    drive_cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0, acc, got, res);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_flags_q", 32'(flags_q), 32'd0);
    run_one(4'h0, 16'h0002, 16'h0003, res, fl);
    check("fl_next_result", 32'(res), 32'd5);

    // Asynchronous reset while two ops are held.
    run_one(4'h1, 16'h0005, 16'h0005, res, fl);
    check("rs_pre_flags_q", 32'(flags_q), 32'b010);
    drive_cycle(1'b1, 4'h0, 16'h0001, 16'h0001, 1'b0, 1'b0, acc, got, res);
    drive_cycle(1'b1, 4'h0, 16'h0002, 16'h0002, 1'b0, 1'b0, acc, got, res);
    drive_cycle(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, acc, got, res);
    check("rs_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_flags_q", 32'(flags_q), 32'd0);
    check("rs_out_result", 32'(out_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("rs_in_ready", 32'(in_ready), 32'd1);
    check("rs_stays_empty", 32'(out_valid), 32'd0);

    // WIDTH=32 instance: rotate wraps bit 0 to the top.
    @(negedge clk);
    in_valid32 = 1'b1; in_op32 = 4'h6; in_a32 = 32'h0000_0001; in_b32 = 32'h0000_0001;
    @(negedge clk);
    in_valid32 = 1'b0;
    n = 0;
    while (!out_valid32 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("w32_latency", 32'(n), 32'd1);
    check("w32_ror", out_result32, 32'h8000_0000);
    check("w32_flags", 32'(out_flags32), 32'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
